button_debouncer_multi: RTL and testbench
=========================================

Name: button_debouncer_multi

Overview:
Parametrised N-channel successor to the single-button debouncer. It synchronises N raw mechanical inputs, debounces each independently with a tick-gated counter, and supports per-channel input polarity. It emits one-cycle press and release pulses, plus long-press and auto-repeat pulses. It sits between board push-buttons or DIP switches and the control FSMs of the systolic-array demo tasks.

Parameters:
N_CH, 4, number of independent input channels (1..32)
CNT_WIDTH, 16, debounce counter width; state flips after 2^CNT_WIDTH consecutive mismatching ticks
ACTIVE_LOW, 1, 1 = raw input pressed when 0 (inverted at sync stage); 0 = pressed when 1; applies to all channels
HOLD_WIDTH, 20, long-press counter width; long press after 2^HOLD_WIDTH-1 ticks held
REP_WIDTH, 18, auto-repeat period counter width; repeat every 2^REP_WIDTH ticks
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = sw_repeat_o tied to 0

Ports:
clk_i  input  1  system clock; all logic is on the rising edge
rst_i  input  1  synchronous, active-high reset
tick_i  input  1  counter-advance strobe; tie to 1 for per-clock counting
sw_i  input  N_CH  raw asynchronous button/switch inputs
sw_state_o  output  N_CH  debounced level per channel, 1 = pressed
sw_down_o  output  N_CH  one-cycle pulse on debounced press
sw_up_o  output  N_CH  one-cycle pulse on debounced release
sw_long_o  output  N_CH  one-cycle pulse when hold reaches long-press threshold
sw_repeat_o  output  N_CH  one-cycle auto-repeat pulses during a long press
any_pressed_o  output  1  OR of sw_state_o, registered

Behaviour:
- Reset: one clock, synchronous, active-high. The reset is fixed by design.
- Reset values: all outputs are 0. Sync flops, debounce counters, hold counters and repeat counters are all 0. Sync reset value is "released" for both polarities.
- Sync: 2-flop synchroniser per channel, sync[1] = synchronised pressed level (raw XOR ACTIVE_LOW). The sync stage runs every clock, independent of tick_i.
- Debounce, per channel:
  - mismatch = (sync[1] != sw_state_o[i]).
  - mismatch=0: counter cleared every clock, tick or not.
  - mismatch=1 and tick_i=1: counter increments.
  - mismatch=1, tick_i=1, counter=all-ones: sw_state_o toggles and the counter wraps to 0.
  - mismatch=1 and tick_i=0: counter holds.
  - Any single clock without mismatch clears progress (glitch rejection).
- Latency with tick_i=1: a clean input change appears on sw_state_o 2+2^CNT_WIDTH clocks after the raw edge.
- Edge pulses:
  - sw_down_o[i] / sw_up_o[i] are registered and asserted in the same cycle sw_state_o takes its new value, for exactly one clock.
  - Never both in one cycle on the same channel.
- Long press, per channel:
  - Hold counter is cleared whenever sw_state_o=0 and in the cycle of a press toggle.
  - While pressed and tick_i=1, it increments until all-ones, then saturates.
  - sw_long_o pulses one clock on the tick where the counter becomes all-ones; once per press.
- Auto-repeat (REPEAT_EN=1):
  - Repeat counter is cleared while the hold counter is not saturated or the channel is released.
  - While saturated, it increments on ticks; sw_repeat_o pulses one clock on the tick where it wraps all-ones to 0.
  - First repeat occurs 2^REP_WIDTH ticks after sw_long_o.
- Release at any point clears hold/repeat state in the same cycle sw_up_o asserts; no long/repeat pulse in or after that cycle.
- Simultaneous events:
  - Channels are fully independent; any number may pulse in one cycle.
  - A press toggle and the long threshold cannot coincide.
- Reset mid-operation: all state clears next edge, with no sw_up_o pulse for channels that were pressed. After reset deassert, a still-held button is re-debounced and generates sw_down_o.
- any_pressed_o: registered OR of sw_state_o; lags sw_state_o by one clock.
- Widths: counters are unsigned and free of overflow beyond the described wrap/saturate rules; no arithmetic crosses channels.

Test Plan:
- N_CH=2, CNT_WIDTH=3, ACTIVE_LOW=1, tick_i=1; drive sw_i[0] 1->0 cleanly -> sw_state_o[0]=1 and sw_down_o[0]=1 for one clock exactly 10 clocks after the edge; channel 1 stays 0.
- Bounce: sw_i[0] low for 5 clocks, high 1 clock, low steady -> no toggle until 8 consecutive mismatching clocks after the last bounce; single sw_down_o pulse.
- tick_i pulsed 1-in-4, CNT_WIDTH=3 -> toggle after 8 ticks (~32 clocks); counter holds on non-tick clocks, and a mismatch gap on a non-tick clock still clears it.
- HOLD_WIDTH=4, REP_WIDTH=2, hold pressed -> sw_long_o once, 15 ticks after sw_down_o. sw_repeat_o pulses 4, 8, 12 ticks after that. Release -> sw_up_o, then no further repeats.
- Both channels pressed on the same clock -> sw_down_o=2'b11 in one cycle; any_pressed_o rises one clock later.
- rst_i asserted while channel 0 pressed and mid-repeat -> next clock all outputs 0 with no sw_up_o. After release of reset with the button held, sw_down_o reappears 2+8 clocks later (CNT_WIDTH=3).

Source files
------------

// File: rtl/button_debouncer_multi.sv
// N-channel push-button debouncer: 2-flop sync, tick-gated debounce, press/release
// pulses, long-press and auto-repeat pulses, all channels fully independent.

module button_debouncer_lane #(
  parameter int CNT_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_WIDTH = 20,
  parameter int REP_WIDTH  = 18,
  parameter int REPEAT_EN  = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic long_o,
  output logic repeat_o
);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic [1:0]            sync_q, sync_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d, hold_inc;
  logic [REP_WIDTH-1:0]  rep_q, rep_d;
  logic                  state_q, state_d;
  logic                  down_q, down_d, up_q, up_d;
  logic                  long_q, long_d, rpt_q, rpt_d;
  logic                  mismatch, toggle, hold_run, hold_sat;

  always_comb begin
    // Stored sync level is "pressed", so reset value 0 means released for either polarity.
    sync_d   = {sync_q[0], sw_i ^ POL};
    mismatch = sync_q[1] ^ state_q;
    toggle   = mismatch & tick_i & (&cnt_q);

    cnt_d = cnt_q;
    if (!mismatch)   cnt_d = '0;
    else if (tick_i) cnt_d = cnt_q + 1'b1;

    state_d = state_q ^ toggle;
    down_d  = toggle & ~state_q;
    up_d    = toggle & state_q;

    // Hold/repeat only run while pressed and not in a toggle cycle, so a release
    // wipes them in the same cycle the up pulse appears.
    hold_run = state_q & ~toggle;
    hold_sat = &hold_q;
    hold_inc = hold_q + 1'b1;
    hold_d   = hold_q;
    long_d   = 1'b0;
    if (!hold_run) hold_d = '0;
    else if (tick_i && !hold_sat) begin
      hold_d = hold_inc;
      long_d = &hold_inc;
    end

    rep_d = rep_q;
    rpt_d = 1'b0;
    if (!(hold_run && hold_sat)) rep_d = '0;
    else if (tick_i) begin
      rep_d = rep_q + 1'b1;
      rpt_d = &rep_q;
    end
    if (REPEAT_EN == 0) begin
      rep_d = '0;
      rpt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      rep_q   <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign state_o  = state_q;
  assign down_o   = down_q;
  assign up_o     = up_q;
  assign long_o   = long_q;
  assign repeat_o = rpt_q;
endmodule

module button_debouncer_multi #(
  parameter int N_CH       = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_WIDTH = 20,
  parameter int REP_WIDTH  = 18,
  parameter int REPEAT_EN  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            tick_i,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] sw_state_o,
  output logic [N_CH-1:0] sw_down_o,
  output logic [N_CH-1:0] sw_up_o,
  output logic [N_CH-1:0] sw_long_o,
  output logic [N_CH-1:0] sw_repeat_o,
  output logic            any_pressed_o
);
  logic any_q, any_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    button_debouncer_lane #(
      .CNT_WIDTH (CNT_WIDTH),
      .ACTIVE_LOW(ACTIVE_LOW),
      .HOLD_WIDTH(HOLD_WIDTH),
      .REP_WIDTH (REP_WIDTH),
      .REPEAT_EN (REPEAT_EN)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .tick_i  (tick_i),
      .sw_i    (sw_i[g]),
      .state_o (sw_state_o[g]),
      .down_o  (sw_down_o[g]),
      .up_o    (sw_up_o[g]),
      .long_o  (sw_long_o[g]),
      .repeat_o(sw_repeat_o[g])
    );
  end

  always_comb any_d = |sw_state_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) any_q <= 1'b0;
    else       any_q <= any_d;
  end

  assign any_pressed_o = any_q;
endmodule

// File: tb/tb_button_debouncer_multi.sv
// Randomized + directed bench for button_debouncer_multi against a tick-counting
// reference model (unbounded hold-tick count, modulo arithmetic for repeats).

module tb_button_debouncer_multi;
  localparam int N  = 2;
  localparam int CW = 3;
  localparam int HW = 4;
  localparam int RW = 2;
  localparam int DEB_TICKS  = 1 << CW;
  localparam int LONG_TICKS = (1 << HW) - 1;
  localparam int REP_TICKS  = 1 << RW;

  logic         clk = 1'b0;
  logic         rst, tick;
  logic [N-1:0] sw, st, dn, up, lg, rp;
  logic         anyp;

  always #5 clk = ~clk;

  button_debouncer_multi #(
    .N_CH(N), .CNT_WIDTH(CW), .ACTIVE_LOW(1), .HOLD_WIDTH(HW), .REP_WIDTH(RW), .REPEAT_EN(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .sw_i(sw),
    .sw_state_o(st), .sw_down_o(dn), .sw_up_o(up), .sw_long_o(lg),
    .sw_repeat_o(rp), .any_pressed_o(anyp)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  // Reference model state
  bit [N-1:0] m_s0, m_s1, m_st;
  int         m_mis[N];
  int         m_held[N];
  bit [N-1:0] e_st, e_dn, e_up, e_lg, e_rp;
  bit         e_any;

  task automatic model_step();
    bit [N-1:0] old_st;
    old_st = m_st;
    e_dn = '0; e_up = '0; e_lg = '0; e_rp = '0;
    if (rst) begin
      m_s0 = '0; m_s1 = '0; m_st = '0; e_any = 1'b0;
      for (int i = 0; i < N; i++) begin m_mis[i] = 0; m_held[i] = 0; end
    end else begin
      for (int i = 0; i < N; i++) begin
        bit flip;
        flip = 1'b0;
        if (m_s1[i] == old_st[i]) m_mis[i] = 0;
        else if (tick) begin
          m_mis[i]++;
          if (m_mis[i] == DEB_TICKS) begin flip = 1'b1; m_mis[i] = 0; end
        end
        if (flip) begin
          m_st[i] = ~old_st[i];
          if (old_st[i]) e_up[i] = 1'b1; else e_dn[i] = 1'b1;
          m_held[i] = 0;
        end else if (!old_st[i]) begin
          m_held[i] = 0;
        end else if (tick) begin
          m_held[i]++;
          if (m_held[i] == LONG_TICKS) e_lg[i] = 1'b1;
          if (m_held[i] > LONG_TICKS && (m_held[i] - LONG_TICKS) % REP_TICKS == 0) e_rp[i] = 1'b1;
        end
      end
      e_any = |old_st;
      m_s1 = m_s0;
      m_s0 = ~sw;
    end
    e_st = m_st;
  endtask

  task automatic cycle(input bit r, input bit t, input logic [N-1:0] s);
    rst = r; tick = t; sw = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("state",  32'(st),   32'(e_st));
    check("down",   32'(dn),   32'(e_dn));
    check("up",     32'(up),   32'(e_up));
    check("long",   32'(lg),   32'(e_lg));
    check("repeat", 32'(rp),   32'(e_rp));
    check("any",    32'(anyp), 32'(e_any));
    check("dn_and_up", 32'(dn & up), 32'd0);
  endtask

  initial begin
    bit [N-1:0] tgt;
    int         since[N];
    bit         t;
    logic [N-1:0] raw;

    rst = 1'b1; tick = 1'b1; sw = '1;
    m_s0 = '0; m_s1 = '0; m_st = '0;
    for (int i = 0; i < N; i++) begin m_mis[i] = 0; m_held[i] = 0; end
    @(negedge clk);
    cycle(1, 1, 2'b11);
    cycle(1, 1, 2'b11);

    // clean press on ch0, long press, repeats, release
    repeat (60) cycle(0, 1, 2'b10);
    repeat (15) cycle(0, 1, 2'b11);
    // bounce then steady press
    repeat (5) cycle(0, 1, 2'b10);
    cycle(0, 1, 2'b11);
    repeat (20) cycle(0, 1, 2'b10);
    repeat (15) cycle(0, 1, 2'b11);
    // both channels on the same clock
    repeat (45) cycle(0, 1, 2'b00);
    // reset mid-repeat with buttons held, then re-debounce
    cycle(1, 1, 2'b00);
    repeat (20) cycle(0, 1, 2'b00);
    repeat (15) cycle(0, 1, 2'b11);
    // 1-in-4 tick with a gap landing on a non-tick clock
    for (int k = 0; k < 80; k++) begin
      raw = (k == 13) ? 2'b11 : 2'b10;
      cycle(0, (k % 4) == 0, raw);
    end
    for (int k = 0; k < 60; k++) cycle(0, (k % 4) == 0, 2'b11);

    // randomized phase
    tgt = '1;
    for (int i = 0; i < N; i++) since[i] = 100;
    for (int k = 0; k < 7000; k++) begin
      case ((k / 700) % 3)
        0:       t = 1'b1;
        1:       t = ($urandom % 4) == 0;
        default: t = $urandom_range(0, 1) != 0;
      endcase
      for (int i = 0; i < N; i++) begin
        since[i]++;
        if ($urandom % 90 == 0) begin tgt[i] = ~tgt[i]; since[i] = 0; end
        raw[i] = tgt[i];
        if (since[i] < 10 && $urandom % 4 == 0) raw[i] = ~tgt[i];
      end
      cycle(($urandom % 900) == 0, t, raw);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
